// File: rtl/mem_fsm_pkg.sv
// Shared types and constants for the memory transfer sequencer.
package mem_fsm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_REQ,
    ST_WAIT,
    ST_CAPT,
    ST_WB,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic OP_LOAD      = 1'b0;
  localparam logic OP_STORE     = 1'b1;

  localparam logic MEM_RW_READ  = 1'b1;
  localparam logic MEM_RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-wait watchdog: down-counter reloaded by clear, expired on terminal count.
module mem_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  // Reload to TIMEOUT-1 so the terminal count is seen during the TIMEOUT-th enabled cycle.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Reload on clear, count down while enabled, hold at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= LOAD_VAL;
    end else if (enable && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/mem_xfer_fsm.sv
// Register <-> memory transfer sequencer driving bus strobes for LOAD and STORE.
//
// state | meaning
// IDLE  | waiting for start; latches op and indices
// ADDR  | address register onto bus, load MAR
// DATA  | STORE only: source register onto bus, load MDR
// REQ   | issue memory request
// WAIT  | hold request until MFC or timeout
// CAPT  | LOAD only: capture memory data into MDR
// WB    | LOAD only: MDR onto bus, write destination register
// DONE  | one-cycle completion pulse
// ERR   | one-cycle abort pulse (bad index or timeout)
module mem_xfer_fsm
  import mem_fsm_pkg::*;
#(
  parameter int NUM_REGS = 5,
  parameter int IDX_W    = 6,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                op,
  input  logic [IDX_W-1:0]    Ri,
  input  logic [IDX_W-1:0]    Rj,
  input  logic                MFC,
  output logic [NUM_REGS-1:0] reg_read,
  output logic [NUM_REGS-1:0] reg_write,
  output logic                MAR_write,
  output logic                MAR_mem_read,
  output logic                MEM_RW,
  output logic                MEM_EN,
  output logic                MDR_mem_write,
  output logic                MDR_mem_read,
  output logic                MDR_write,
  output logic                MDR_read,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

  state_t           state_q, state_d;
  logic             op_q;
  logic [IDX_W-1:0] ri_q, rj_q;
  logic             idx_bad;
  logic             tmr_clear, tmr_enable, tmr_expired;

  assign idx_bad    = (32'(Ri) >= NUM_REGS) || (32'(Rj) >= NUM_REGS);
  assign tmr_clear  = (state_q == ST_REQ);
  assign tmr_enable = (state_q == ST_WAIT);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the request only when accepted in IDLE; later input changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= OP_LOAD;
      ri_q <= '0;
      rj_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      op_q <= op;
      ri_q <= Ri;
      rj_q <= Rj;
    end
  end

  // Next-state decode; MFC matters only in WAIT and wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = idx_bad ? ST_ERR : ST_ADDR;
      ST_ADDR: state_d = (op_q == OP_LOAD) ? ST_REQ : ST_DATA;
      ST_DATA: state_d = ST_REQ;
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (MFC)              state_d = (op_q == OP_LOAD) ? ST_CAPT : ST_DONE;
        else if (tmr_expired) state_d = ST_ERR;
      end
      ST_CAPT: state_d = ST_WB;
      ST_WB:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore strobes from state and latched request.
  always_comb begin
    reg_read      = '0;
    reg_write     = '0;
    MAR_write     = 1'b0;
    MAR_mem_read  = 1'b0;
    MEM_RW        = MEM_RW_WRITE;
    MEM_EN        = 1'b0;
    MDR_mem_write = 1'b0;
    MDR_mem_read  = 1'b0;
    MDR_write     = 1'b0;
    MDR_read      = 1'b0;
    busy          = (state_q != ST_IDLE);
    done          = 1'b0;
    err           = 1'b0;
    case (state_q)
      ST_ADDR: begin
        MAR_write = 1'b1;
        reg_read  = (op_q == OP_LOAD) ? (ONE << ri_q) : (ONE << rj_q);
      end
      ST_DATA: begin
        reg_read  = ONE << ri_q;
        MDR_write = 1'b1;
      end
      ST_REQ, ST_WAIT: begin
        MAR_mem_read = 1'b1;
        MEM_EN       = 1'b1;
        if (op_q == OP_LOAD) begin
          MEM_RW = MEM_RW_READ;
        end else begin
          MEM_RW       = MEM_RW_WRITE;
          MDR_mem_read = 1'b1;
        end
      end
      ST_CAPT: MDR_mem_write = 1'b1;
      ST_WB: begin
        MDR_read  = 1'b1;
        reg_write = ONE << rj_q;
      end
      ST_DONE: done = 1'b1;
      ST_ERR:  err  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_xfer_fsm.sv
// Directed bench for mem_xfer_fsm with a short timeout (TIMEOUT=4).
module tb_mem_xfer_fsm;
  import mem_fsm_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start, op, MFC;
  logic [5:0] Ri, Rj;
  logic [4:0] reg_read, reg_write;
  logic       MAR_write, MAR_mem_read, MEM_RW, MEM_EN;
  logic       MDR_mem_write, MDR_mem_read, MDR_write, MDR_read;
  logic       busy, done, err;

  mem_xfer_fsm #(.NUM_REGS(5), .IDX_W(6), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .Ri(Ri), .Rj(Rj), .MFC(MFC),
    .reg_read(reg_read), .reg_write(reg_write),
    .MAR_write(MAR_write), .MAR_mem_read(MAR_mem_read),
    .MEM_RW(MEM_RW), .MEM_EN(MEM_EN),
    .MDR_mem_write(MDR_mem_write), .MDR_mem_read(MDR_mem_read),
    .MDR_write(MDR_write), .MDR_read(MDR_read),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [10:0] ctl;
  assign ctl = {busy, done, err, MAR_write, MAR_mem_read, MEM_RW, MEM_EN,
                MDR_mem_write, MDR_mem_read, MDR_write, MDR_read};

  localparam logic [10:0] C_BUSY  = 11'h400;
  localparam logic [10:0] C_DONE  = 11'h200;
  localparam logic [10:0] C_ERR   = 11'h100;
  localparam logic [10:0] C_MARW  = 11'h080;
  localparam logic [10:0] C_MARR  = 11'h040;
  localparam logic [10:0] C_RW    = 11'h020;
  localparam logic [10:0] C_EN    = 11'h010;
  localparam logic [10:0] C_MDRMW = 11'h008;
  localparam logic [10:0] C_MDRMR = 11'h004;
  localparam logic [10:0] C_MDRW  = 11'h002;
  localparam logic [10:0] C_MDRR  = 11'h001;
  localparam logic [10:0] C_LREQ  = C_BUSY | C_MARR | C_RW | C_EN;
  localparam logic [10:0] C_SREQ  = C_BUSY | C_MARR | C_EN | C_MDRMR;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [10:0] c, input logic [4:0] rr, input logic [4:0] rw);
    tick();
    check_val({tag, ".ctl"}, 32'(ctl), 32'(c));
    check_val({tag, ".rr"}, 32'(reg_read), 32'(rr));
    check_val({tag, ".rw"}, 32'(reg_write), 32'(rw));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = OP_LOAD; Ri = '0; Rj = '0; MFC = 1'b0;
    #12;
    check_val("reset.ctl", 32'(ctl), 32'd0);
    check_val("reset.rr", 32'(reg_read), 32'd0);
    check_val("reset.rw", 32'(reg_write), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // LOAD R2 -> R4, MFC on 3rd WAIT cycle; done in cycle 8
    start = 1'b1; op = OP_LOAD; Ri = 6'd2; Rj = 6'd4;
    step("ld.addr", C_BUSY | C_MARW, 5'b00100, 5'b0); start = 1'b0;
    step("ld.req",  C_LREQ, 5'b0, 5'b0);
    step("ld.w1",   C_LREQ, 5'b0, 5'b0);
    step("ld.w2",   C_LREQ, 5'b0, 5'b0);
    step("ld.w3",   C_LREQ, 5'b0, 5'b0); MFC = 1'b1;
    step("ld.capt", C_BUSY | C_MDRMW, 5'b0, 5'b0); MFC = 1'b0;
    step("ld.wb",   C_BUSY | C_MDRR, 5'b0, 5'b10000);
    step("ld.done", C_BUSY | C_DONE, 5'b0, 5'b0);
    step("ld.idle", 11'h0, 5'b0, 5'b0);

    // STORE R1 -> mem[R3], MFC on 1st WAIT cycle; done in cycle 5
    start = 1'b1; op = OP_STORE; Ri = 6'd1; Rj = 6'd3;
    step("st.addr", C_BUSY | C_MARW, 5'b01000, 5'b0); start = 1'b0;
    step("st.data", C_BUSY | C_MDRW, 5'b00010, 5'b0);
    step("st.req",  C_SREQ, 5'b0, 5'b0);
    step("st.w1",   C_SREQ, 5'b0, 5'b0); MFC = 1'b1;
    step("st.done", C_BUSY | C_DONE, 5'b0, 5'b0); MFC = 1'b0;
    start = 1'b1; op = OP_LOAD; Ri = 6'd0; Rj = 6'd1;
    step("st.idle", 11'h0, 5'b0, 5'b0); MFC = 1'b1;

    // Back-to-back start, stray MFC in IDLE/ADDR, then timeout after 4 WAIT cycles
    step("to.addr", C_BUSY | C_MARW, 5'b00001, 5'b0); start = 1'b0;
    step("to.req",  C_LREQ, 5'b0, 5'b0); MFC = 1'b0;
    for (int i = 0; i < 4; i++) step($sformatf("to.w%0d", i + 1), C_LREQ, 5'b0, 5'b0);
    step("to.err",  C_BUSY | C_ERR, 5'b0, 5'b0);
    step("to.idle", 11'h0, 5'b0, 5'b0);

    // Out-of-range indices abort straight from IDLE
    start = 1'b1; op = OP_LOAD; Ri = 6'd7; Rj = 6'd0;
    step("badi.err",  C_BUSY | C_ERR, 5'b0, 5'b0); start = 1'b0;
    step("badi.idle", 11'h0, 5'b0, 5'b0);
    start = 1'b1; op = OP_STORE; Ri = 6'd0; Rj = 6'd5;
    step("badj.err",  C_BUSY | C_ERR, 5'b0, 5'b0); start = 1'b0;
    step("badj.idle", 11'h0, 5'b0, 5'b0);

    // Inputs changed after accept, start pulsed in WAIT, MFC on the expiring cycle
    start = 1'b1; op = OP_LOAD; Ri = 6'd3; Rj = 6'd0;
    step("hold.addr", C_BUSY | C_MARW, 5'b01000, 5'b0);
    start = 1'b0; op = OP_STORE; Ri = 6'd1; Rj = 6'd2;
    step("hold.req",  C_LREQ, 5'b0, 5'b0);
    step("hold.w1",   C_LREQ, 5'b0, 5'b0); start = 1'b1;
    step("hold.w2",   C_LREQ, 5'b0, 5'b0); start = 1'b0;
    step("hold.w3",   C_LREQ, 5'b0, 5'b0);
    step("hold.w4",   C_LREQ, 5'b0, 5'b0); MFC = 1'b1;
    step("hold.capt", C_BUSY | C_MDRMW, 5'b0, 5'b0); MFC = 1'b0;
    step("hold.wb",   C_BUSY | C_MDRR, 5'b0, 5'b00001);
    step("hold.done", C_BUSY | C_DONE, 5'b0, 5'b0);
    step("hold.idle", 11'h0, 5'b0, 5'b0);

    // Asynchronous reset in WAIT, then a clean LOAD
    start = 1'b1; op = OP_LOAD; Ri = 6'd0; Rj = 6'd2;
    step("rs.addr", C_BUSY | C_MARW, 5'b00001, 5'b0); start = 1'b0;
    step("rs.req",  C_LREQ, 5'b0, 5'b0);
    step("rs.w1",   C_LREQ, 5'b0, 5'b0);
    #3 reset = 1'b1;
    #1;
    check_val("rs.async.ctl", 32'(ctl), 32'd0);
    check_val("rs.async.rr", 32'(reg_read), 32'd0);
    check_val("rs.async.rw", 32'(reg_write), 32'd0);
    step("rs.held", 11'h0, 5'b0, 5'b0);
    reset = 1'b0;
    start = 1'b1; op = OP_LOAD; Ri = 6'd4; Rj = 6'd1;
    step("cl.addr", C_BUSY | C_MARW, 5'b10000, 5'b0); start = 1'b0;
    step("cl.req",  C_LREQ, 5'b0, 5'b0);
    step("cl.w1",   C_LREQ, 5'b0, 5'b0); MFC = 1'b1;
    step("cl.capt", C_BUSY | C_MDRMW, 5'b0, 5'b0); MFC = 1'b0;
    step("cl.wb",   C_BUSY | C_MDRR, 5'b0, 5'b00010);
    step("cl.done", C_BUSY | C_DONE, 5'b0, 5'b0);
    step("cl.idle", 11'h0, 5'b0, 5'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_xfer_fsm.md
MEM_XFER_FSM -- requirements
Module: mem_xfer_fsm

Interface
REQ-001 SHALL have parameter NUM_REGS, default 5, meaning the number of register-file ports driven, 1..32.
REQ-002 SHALL have parameter IDX_W, default 6, meaning the width of the register index inputs.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum WAIT cycles before abort, 1..65535.
REQ-004 Port clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 Port reset  in  1  reset, asynchronous and active-high.
REQ-006 Port start  in  1  request a transfer; sampled only in IDLE.
REQ-007 Port op  in  1  0 = LOAD (mem[R[Ri]] -> R[Rj]); 1 = STORE (R[Ri] -> mem[R[Rj]]).
REQ-008 Port Ri, Rj  in  IDX_W each  register indices.
REQ-009 Port MFC  in  1  memory function complete, active-high.
REQ-010 Port reg_read  out  NUM_REGS  one-hot register-to-bus enables.
REQ-011 Port reg_write  out  NUM_REGS  one-hot bus-to-register enables.
REQ-012 Port MAR_write, MAR_mem_read  out  1 each  MAR load from bus; MAR drive to memory.
REQ-013 Port MEM_RW, MEM_EN  out  1 each  1 = read, 0 = write; memory enable.
REQ-014 Port MDR_mem_write, MDR_mem_read, MDR_write, MDR_read  out  1 each  MDR load from memory; MDR drive to memory; MDR load from bus; MDR drive to bus.
REQ-015 Port busy, done, err  out  1 each  transfer in progress; one-cycle completion pulse; one-cycle abort pulse.

Function
REQ-016 States SHALL be IDLE, ADDR, DATA, REQ, WAIT, CAPT, WB, DONE, ERR.
REQ-017 IDLE with start=1 SHALL latch op, Ri and Rj, then go to ADDR; start SHALL be ignored in every other state.
REQ-018 After the latch, Ri and Rj input changes SHALL have no effect.
REQ-019 On accepted start, a latched Ri or Rj >= NUM_REGS SHALL send IDLE directly to ERR with no memory or register strobe.
REQ-020 Outputs SHALL be Moore: a function of state and the latched op/indices only; all strobes not listed for a state SHALL be 0.
REQ-021 ADDR: MAR_write=1; reg_read[Ri] for LOAD, reg_read[Rj] for STORE; next LOAD->REQ, STORE->DATA.
REQ-022 DATA (STORE only): reg_read[Ri]=1, MDR_write=1; next REQ.
REQ-023 REQ: MAR_mem_read=1, MEM_EN=1; MEM_RW=1 for LOAD; MEM_RW=0 and MDR_mem_read=1 for STORE; next WAIT.
REQ-024 WAIT SHALL hold the REQ outputs and count cycles; MFC=1 SHALL go LOAD->CAPT, STORE->DONE; TIMEOUT cycles without MFC SHALL go to ERR.
REQ-025 MFC=1 in the same cycle the count reaches TIMEOUT SHALL take the MFC path.
REQ-026 CAPT: MDR_mem_write=1; next WB.
REQ-027 WB: MDR_read=1, reg_write[Rj]=1; next DONE.
REQ-028 DONE SHALL assert done=1 for exactly one cycle; ERR SHALL assert err=1 for exactly one cycle; both SHALL then go to IDLE.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 MFC outside WAIT SHALL be ignored.
REQ-031 LOAD latency, start to done, SHALL be 5 + w cycles; STORE latency SHALL be 4 + w cycles; w = WAIT cycles, w >= 1.
REQ-032 A new start SHALL be accepted in the cycle after DONE or ERR.

Reset
REQ-033 reset=1 SHALL force IDLE immediately, including mid-transfer, with every output 0 and the wait counter cleared.
REQ-034 Latched op/indices SHALL reset to 0; the first post-reset start SHALL be sampled on the first rising edge after reset deasserts.

Structure
REQ-035 A shared package mem_fsm_pkg SHALL hold the state enumeration, the OP_LOAD/OP_STORE constants and the MEM_RW read/write constants.
REQ-036 The wait counter SHALL be a sub-module mem_wait_timer with a clear input, an enable input and an expired output, width $clog2(TIMEOUT+1).

Verification
REQ-037 LOAD Ri=2, Rj=4, MFC high on the 3rd WAIT cycle -> reg_read[2]+MAR_write, REQ, 3 WAIT, CAPT, reg_write[4]+MDR_read, done at cycle 8.
REQ-038 STORE Ri=1, Rj=3, MFC on the 1st WAIT cycle -> ADDR reg_read[3], DATA reg_read[1]+MDR_write, REQ MEM_RW=0, done at cycle 5.
REQ-039 TIMEOUT=4 with MFC held 0 -> err pulse after 4 WAIT cycles, busy falls, no reg_write ever asserted.
REQ-040 Ri=7 with NUM_REGS=5 -> err on the cycle after start, MEM_EN never 1.
REQ-041 reset asserted in WAIT -> all outputs 0 asynchronously; later start runs a clean LOAD.
REQ-042 start pulsed in WAIT and Ri changed after accept -> both ignored, original transfer completes unchanged.
